// File: rtl/line_mem_if.sv
// Line-granular request/grant bus between a cache miss path (master) and main memory (slave).
interface line_mem_if #(
    parameter int unsigned ADDR_LEN      = 10,
    parameter int unsigned LINE_ADDR_LEN = 3
);
    localparam int unsigned WORDS = 1 << LINE_ADDR_LEN;

    logic [ADDR_LEN-1:0]    addr;
    logic                   rd_req;
    logic                   wr_req;
    logic [WORDS-1:0][31:0] wr_line;
    logic                   gnt;
    logic [WORDS-1:0][31:0] rd_line;

    modport master (output addr, rd_req, wr_req, wr_line, input gnt, rd_line);
    modport slave  (input addr, rd_req, wr_req, wr_line, output gnt, rd_line);
endinterface

// File: rtl/line_mem_responder.sv
// Slow main-memory responder: completes line reads/writes LATENCY cycles after acceptance.
// Define LINE_MEM_PRELOAD_EN to have reset fill every word with its own word address.
module line_mem_responder #(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned ADDR_LEN      = 10,
    parameter int unsigned LATENCY       = 50
) (
    input  logic       clk,
    input  logic       rst,
    line_mem_if.slave  bus
);
    localparam int unsigned WORDS = 1 << LINE_ADDR_LEN;
    localparam int unsigned LINES = 1 << ADDR_LEN;
    localparam int unsigned CNT_W = 16;

    typedef logic [WORDS-1:0][31:0] line_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic                op_wr_q, op_wr_d;
    line_t               line_q, line_d;
    logic                gnt_q, gnt_d;
    line_t               rd_line_q, rd_line_d;
    logic                mem_we_c;
    logic                req_live_c;

    line_t mem_q [LINES];

    // The request that was latched must stay asserted, otherwise the transfer is abandoned.
    assign req_live_c = op_wr_q ? bus.wr_req : bus.rd_req;

    always_ff @(posedge clk or posedge rst) begin : ctrl_regs
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            op_wr_q   <= 1'b0;
            line_q    <= '0;
            gnt_q     <= 1'b0;
            rd_line_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            op_wr_q   <= op_wr_d;
            line_q    <= line_d;
            gnt_q     <= gnt_d;
            rd_line_q <= rd_line_d;
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        op_wr_d   = op_wr_q;
        line_d    = line_q;
        gnt_d     = 1'b0;
        rd_line_d = rd_line_q;
        mem_we_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.wr_req || bus.rd_req) begin
                    addr_d  = bus.addr;
                    op_wr_d = bus.wr_req;
                    line_d  = bus.wr_line;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!req_live_c) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    mem_we_c = op_wr_q;
                    if (!op_wr_q) rd_line_d = mem_q[addr_q];
                    gnt_d   = 1'b1;
                    state_d = DONE;
                end
            end
            // Requests are ignored here so a still-falling request is not granted twice.
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef LINE_MEM_PRELOAD_EN
    always_ff @(posedge clk or posedge rst) begin : mem_array
        if (rst) begin
            for (int unsigned l = 0; l < LINES; l++) begin
                for (int unsigned w = 0; w < WORDS; w++) begin
                    mem_q[l][w] <= 32'((l << LINE_ADDR_LEN) | w);
                end
            end
        end else if (mem_we_c) begin
            mem_q[addr_q] <= line_q;
        end
    end
`else
    always_ff @(posedge clk) begin : mem_array
        if (mem_we_c) mem_q[addr_q] <= line_q;
    end
`endif

    assign bus.gnt     = gnt_q;
    assign bus.rd_line = rd_line_q;
endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

- Slow, line-granular main-memory responder.
- Serves the cache's miss path: it completes line reads (swap-in) and line writes (swap-out) after a programmable latency.
- Completion is signalled with a one-cycle `gnt` pulse.
- Sits directly below the cache, on the other end of its `rd_req`/`wr_req`/`gnt` line interface.

## Interface
- `LINE_ADDR_LEN`, default 3: words per line = 2^LINE_ADDR_LEN.
- `ADDR_LEN`, default 10: line address width; storage is 2^ADDR_LEN lines.
- `LATENCY`, default 50: request-to-grant delay in cycles; legal range 1..65535.
- `clk`  in  1: the block's single clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `addr`  in  ADDR_LEN: line address; sampled when a request is accepted.
- `rd_req`  in  1: line read request, held high until `gnt` is seen.
- `wr_req`  in  1: line write request, held high until `gnt` is seen.
- `wr_line`  in  32 x 2^LINE_ADDR_LEN: write data; sampled when a request is accepted.
- `gnt`  out  1: one-cycle completion pulse.
- `rd_line`  out  32 x 2^LINE_ADDR_LEN: registered read line.

## Operation
**States:** IDLE, BUSY, DONE.

**IDLE**
- On `wr_req | rd_req`, latch the following and go to BUSY:
  - `addr`
  - the operation; `wr_req` has priority if both are high, and the read is then re-sampled on the next IDLE
  - `wr_line`
- Load `cnt <= LATENCY-1`.

**BUSY**
- While `cnt != 0`: `cnt <= cnt-1`.
- At `cnt == 0`:
  - Write: `mem[latched addr] <= latched line`.
  - Read: `rd_line <= mem[latched addr]`.
  - Then `gnt <= 1` and go to DONE.
- Abort: if the latched request input is low in BUSY, return to IDLE with no array write, no `rd_line` update and no `gnt`.

**DONE**
- `gnt <= 0`, go to IDLE.
- Request inputs are ignored this cycle.
- This prevents re-granting a request the initiator is still dropping.

**Data rules**
- `rd_line` holds its value until the next read completion; the initiator consumes it the cycle after `gnt`.
- The array is never reset, except under the configuration macro.
- The latch-and-count path is 16-bit.
- A write followed by a read of the same line returns the written data.

## Timing
- Request accepted at edge T0 (IDLE).
- The array update and `rd_line` load occur at edge T0+LATENCY.
- `gnt` is high for exactly the cycle between edges T0+LATENCY and T0+LATENCY+1.
- Next acceptance is possible at the earliest at edge T0+LATENCY+2.
- Back-to-back swap-out then swap-in, where `wr_req` falls and `rd_req` rises in the cycle after `gnt`:
  - the read is accepted at the edge ending that cycle;
  - the read's `gnt` arrives LATENCY edges later.
- LATENCY=1: `gnt` rises one edge after acceptance.
- Reset values: `gnt`=0, `rd_line`=all zero, state IDLE, `cnt`=0, latches=0.
- `rst` asserted mid-BUSY: `gnt` goes low immediately, state goes to IDLE, and the pending write is discarded.

## Configuration
- `LINE_MEM_PRELOAD_EN` defined:
  - Reset initialises every array word with its word address, (line << LINE_ADDR_LEN) | index, zero-extended to 32 bits.
  - Benches get deterministic read data without prior writes.
- Not defined:
  - Array contents are uninitialised (X in simulation) until written.
  - Reset touches only control state and `rd_line`.

## Test plan
- Preload on, LATENCY=4: `rd_req` with `addr`=5 accepted at T0 → `gnt` high only in cycle T0+4..T0+5; `rd_line[i]` = 40+i (i=0..7).
- `wr_req`, `addr`=3, `wr_line[i]`=0xA0+i, then `rd_req` `addr`=3 issued the cycle after `gnt` → second `gnt` 4 edges after acceptance; `rd_line[i]`=0xA0+i.
- LATENCY=1: read of `addr`=0 → `gnt` one edge after acceptance; `rd_line` = 0..7; exactly one `gnt` despite `rd_req` high through the DONE cycle.
- `rd_req` and `wr_req` both high, `addr`=2 → the write completes first with one `gnt`; the read is re-accepted after DONE and returns the written line.
- `rd_req` dropped at cycle 2 of BUSY (LATENCY=4) → no `gnt`, `rd_line` unchanged; state back in IDLE.
- `rst` pulse mid-BUSY of a write to `addr`=7 → `gnt`=0, `rd_line`=0; a subsequent read of `addr`=7 returns preload values 56..63.
